// File: rtl/cpu_defs.sv
// Shared types for the fetch-to-issue decode queue: branch classes, opcode
// constants and the stored entry layout.
package cpu_defs;

   typedef enum logic [2:0] {
      B_INVA = 3'd0,
      B_EQNE = 3'd1,
      B_LTGE = 3'd2,
      B_JUMP = 3'd3,
      B_JREG = 3'd4
   } branch_t;

   localparam logic [5:0] SPECIAL  = 6'b000000;
   localparam logic [5:0] REGIMM   = 6'b000001;
   localparam logic [5:0] SPECIAL2 = 6'b011100;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      branch_t     branch;
      logic        is_branch;
      logic        is_link;
      logic        is_hilo;
   } dq_entry_t;

endpackage

// File: rtl/predecode.sv
// Combinational predecode of one MIPS instruction word into branch class,
// link flag and HI/LO-access flag.
module predecode
   import cpu_defs::*;
(
   input  logic [31:0] instr,
   output branch_t     branch,
   output logic        is_branch,
   output logic        is_link,
   output logic        is_hilo
);

   logic [5:0] opcode;
   logic [4:0] rt;
   logic [5:0] funct;
   logic       unused_fields;

   assign opcode = instr[31:26];
   assign rt     = instr[20:16];
   assign funct  = instr[5:0];

   // Register fields and immediates play no part in classification.
   assign unused_fields = ^{instr[25:21], instr[15:6]};

   // Branch class and link flag.
   always_comb begin
      branch  = B_INVA;
      is_link = 1'b0;
      if (opcode[5:2] == 4'b0001) begin
         branch = B_EQNE;
      end else if (opcode == REGIMM && rt[3:1] == 3'b000) begin
         branch  = B_LTGE;
         is_link = rt[4];
      end else if (opcode[5:1] == 5'b00001) begin
         branch  = B_JUMP;
         is_link = opcode[0];
      end else if (opcode == SPECIAL && funct[5:1] == 5'b00100) begin
         branch  = B_JREG;
         is_link = funct[0];
      end
   end

   assign is_branch = (branch != B_INVA);

   // HI/LO access: MFHI/MTHI/MFLO/MTLO, MULT/DIV family, and SPECIAL2 MADD/MSUB/MUL.
   always_comb begin
      is_hilo = 1'b0;
      if (opcode == SPECIAL) begin
         is_hilo = (funct[5:2] == 4'b0100) || (funct[5:2] == 4'b0110);
      end else if (opcode == SPECIAL2 && funct[5:3] == 3'b000) begin
         is_hilo = (funct[2:0] == 3'b000) || (funct[2:0] == 3'b001) ||
                   (funct[2:0] == 3'b010) || (funct[2:0] == 3'b100) ||
                   (funct[2:0] == 3'b101);
      end
   end

endmodule

// File: rtl/decode_queue.sv
// Decode queue between fetch and issue: predecodes incoming lanes into a
// circular buffer and presents a legal issue group from the head.
module decode_queue
   import cpu_defs::*;
#(
   parameter int unsigned FETCH_WIDTH = 2,
   parameter int unsigned ISSUE_WIDTH = 2,
   parameter int unsigned DEPTH       = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic [FETCH_WIDTH-1:0]             in_valid,
   input  logic [32*FETCH_WIDTH-1:0]          in_instr,
   input  logic [32*FETCH_WIDTH-1:0]          in_pc,
   output logic                               in_ready,
   output logic [ISSUE_WIDTH-1:0]             out_valid,
   output logic [32*ISSUE_WIDTH-1:0]          out_instr,
   output logic [32*ISSUE_WIDTH-1:0]          out_pc,
   output logic [3*ISSUE_WIDTH-1:0]           out_branch_type,
   output logic [ISSUE_WIDTH-1:0]             out_is_branch,
   output logic [ISSUE_WIDTH-1:0]             out_is_link,
   output logic [ISSUE_WIDTH-1:0]             out_is_hilo,
   input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   issue_count
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned ICW = $clog2(ISSUE_WIDTH + 1);

   dq_entry_t        mem [DEPTH];
   logic [PW-1:0]    head_q, tail_q;
   logic [CW-1:0]    count_q, count_d;

   branch_t          wr_branch [FETCH_WIDTH];
   logic [FETCH_WIDTH-1:0] wr_is_branch, wr_is_link, wr_is_hilo;
   dq_entry_t        wr_entry [FETCH_WIDTH];
   logic [PW-1:0]    wr_off [FETCH_WIDTH];
   logic [CW-1:0]    push_n, push_cnt;

   dq_entry_t        lane_entry [ISSUE_WIDTH];
   logic             blocked, hilo_seen;
   logic [ICW-1:0]   valid_n, pop_n;

   // Predecode every fetch lane before it is written.
   for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_pd
      predecode u_predecode (
         .instr     (in_instr[32*g +: 32]),
         .branch    (wr_branch[g]),
         .is_branch (wr_is_branch[g]),
         .is_link   (wr_is_link[g]),
         .is_hilo   (wr_is_hilo[g])
      );
      assign wr_entry[g] = '{instr:     in_instr[32*g +: 32],
                             pc:        in_pc[32*g +: 32],
                             branch:    wr_branch[g],
                             is_branch: wr_is_branch[g],
                             is_link:   wr_is_link[g],
                             is_hilo:   wr_is_hilo[g]};
   end

   // Ready depends only on registered occupancy; same-cycle pops are not credited.
   assign in_ready = (CW'(DEPTH) - count_q) >= CW'(FETCH_WIDTH);

   // Slot offset of each valid lane relative to tail, and total lanes accepted.
   always_comb begin
      push_n = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         wr_off[i] = PW'(push_n);
         if (in_valid[i]) push_n = push_n + CW'(1);
      end
      push_cnt = in_ready ? push_n : '0;
   end

   // Present head entries and mask lanes that would form an illegal group.
   always_comb begin
      blocked   = 1'b0;
      hilo_seen = 1'b0;
      valid_n   = '0;
      out_valid = '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         lane_entry[k] = mem[head_q + PW'(k)];
         if (!blocked) begin
            if (k >= int'(count_q)) begin
               blocked = 1'b1;
            end else if (lane_entry[k].is_hilo && hilo_seen) begin
               blocked = 1'b1;
            end else if (int'(ISSUE_WIDTH) > 1 && lane_entry[k].is_branch &&
                         (k + 1 >= int'(count_q) || k + 1 >= int'(ISSUE_WIDTH))) begin
               // Branch must travel with its delay slot in the same group.
               blocked = 1'b1;
            end else begin
               out_valid[k] = 1'b1;
               valid_n      = valid_n + ICW'(1);
               hilo_seen    = hilo_seen | lane_entry[k].is_hilo;
            end
         end
      end
      pop_n = (issue_count > valid_n) ? valid_n : issue_count;
   end

   // Unpack lane entries onto the flat output buses.
   always_comb begin
      out_instr       = '0;
      out_pc          = '0;
      out_branch_type = '0;
      out_is_branch   = '0;
      out_is_link     = '0;
      out_is_hilo     = '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         out_instr[32*k +: 32]      = lane_entry[k].instr;
         out_pc[32*k +: 32]         = lane_entry[k].pc;
         out_branch_type[3*k +: 3]  = lane_entry[k].branch;
         out_is_branch[k]           = lane_entry[k].is_branch;
         out_is_link[k]             = lane_entry[k].is_link;
         out_is_hilo[k]             = lane_entry[k].is_hilo;
      end
   end

   assign count_d = count_q + push_cnt - CW'(pop_n);

   // Pointers and occupancy; flush discards any same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + PW'(pop_n);
         tail_q  <= tail_q + PW'(push_cnt);
         count_q <= count_d;
      end
   end

   // Entry storage is not reset; only accepted lanes are written.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (in_ready && in_valid[i]) mem[tail_q + wr_off[i]] <= wr_entry[i];
      end
   end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios then random traffic, all checked
// against a queue-based reference model of the issue rules.
module tb_decode_queue;
   import cpu_defs::*;

   localparam int FW = 2;
   localparam int IW = 2;
   localparam int D  = 8;

   localparam logic [31:0] ADDU   = 32'h00221821;
   localparam logic [31:0] BEQ    = 32'h10220003;
   localparam logic [31:0] MULT   = 32'h00430018;
   localparam logic [31:0] MFLO   = 32'h00001012;
   localparam logic [31:0] BGEZAL = 32'h04310002;
   localparam logic [31:0] JALR   = 32'h0040F809;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic [1:0]  in_valid;
   logic [63:0] in_instr, in_pc;
   logic        in_ready;
   logic [1:0]  out_valid;
   logic [63:0] out_instr, out_pc;
   logic [5:0]  out_branch_type;
   logic [1:0]  out_is_branch, out_is_link, out_is_hilo;
   logic [1:0]  issue_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ment_t;
   ment_t mq[$];

   typedef struct packed {
      logic [2:0] bt;
      logic       br;
      logic       lk;
      logic       hl;
   } cls_t;

   logic [31:0] table_w [16];

   decode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(D)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_instr        (in_instr),
      .in_pc           (in_pc),
      .in_ready        (in_ready),
      .out_valid       (out_valid),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .out_branch_type (out_branch_type),
      .out_is_branch   (out_is_branch),
      .out_is_link     (out_is_link),
      .out_is_hilo     (out_is_hilo),
      .issue_count     (issue_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Classification from numeric opcode/funct ranges.
   function automatic cls_t classify(input logic [31:0] w);
      cls_t c;
      int op, rt, fn;
      op = int'(w[31:26]);
      rt = int'(w[20:16]);
      fn = int'(w[5:0]);
      c  = '0;
      if (op >= 4 && op <= 7) begin
         c.bt = 3'd1;
      end else if (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)) begin
         c.bt = 3'd2;
         c.lk = (rt >= 16);
      end else if (op == 2 || op == 3) begin
         c.bt = 3'd3;
         c.lk = (op == 3);
      end else if (op == 0 && (fn == 8 || fn == 9)) begin
         c.bt = 3'd4;
         c.lk = (fn == 9);
      end
      c.br = (c.bt != 3'd0);
      c.hl = (op == 0 && ((fn >= 16 && fn <= 19) || (fn >= 24 && fn <= 27))) ||
             (op == 28 && (fn == 0 || fn == 1 || fn == 2 || fn == 4 || fn == 5));
      return c;
   endfunction

   // Number of head entries forming a legal issue group.
   function automatic int exp_lanes();
      int   n;
      logic hs;
      cls_t c;
      n  = mq.size();
      hs = 1'b0;
      for (int k = 0; k < IW; k++) begin
         if (k >= n) return k;
         c = classify(mq[k].instr);
         if (c.hl && hs) return k;
         if (IW > 1 && c.br && (k + 1 >= n || k + 1 >= IW)) return k;
         hs = hs | c.hl;
      end
      return IW;
   endfunction

   task automatic check_outputs(input string where);
      int   nv;
      cls_t c;
      nv = exp_lanes();
      chk({where, " in_ready"}, 32'(in_ready), 32'((D - mq.size()) >= FW));
      chk({where, " out_valid"}, 32'(out_valid), 32'((1 << nv) - 1));
      for (int k = 0; k < IW; k++) begin
         if (k < mq.size()) begin
            c = classify(mq[k].instr);
            chk($sformatf("%s lane%0d instr", where, k), out_instr[32*k +: 32], mq[k].instr);
            chk($sformatf("%s lane%0d pc", where, k), out_pc[32*k +: 32], mq[k].pc);
            chk($sformatf("%s lane%0d btype", where, k), 32'(out_branch_type[3*k +: 3]),
                32'(c.bt));
            chk($sformatf("%s lane%0d flags", where, k),
                32'({out_is_branch[k], out_is_link[k], out_is_hilo[k]}),
                32'({c.br, c.lk, c.hl}));
         end
      end
   endtask

   // One clock: check current outputs, drive inputs, advance the model.
   task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] ic,
                       input logic fl, input logic rs, input string where);
      int   nv, pop;
      logic ready;
      check_outputs(where);
      rst         = rs;
      flush       = fl;
      in_valid    = v;
      in_instr    = {i1, i0};
      in_pc       = {p1, p0};
      issue_count = ic;
      nv          = exp_lanes();
      ready       = (D - mq.size()) >= FW;
      @(posedge clk);
      #1;
      if (rs || fl) begin
         mq.delete();
      end else begin
         pop = (int'(ic) < nv) ? int'(ic) : nv;
         repeat (pop) void'(mq.pop_front());
         if (ready && v[0]) mq.push_back('{instr: i0, pc: p0});
         if (ready && v[1]) mq.push_back('{instr: i1, pc: p1});
      end
      rst         = 1'b0;
      flush       = 1'b0;
      in_valid    = '0;
      issue_count = '0;
   endtask

   initial begin
      logic [31:0] pc, w0, w1;
      logic [1:0]  v, ic;
      int          r;

      table_w = '{32'h00221821, 32'h10220003, 32'h14220003, 32'h00430018,
                  32'h00001012, 32'h00400011, 32'h04310002, 32'h04200002,
                  32'h08000040, 32'h0C000040, 32'h00400008, 32'h0040F809,
                  32'h70430000, 32'h70430004, 32'h70431002, 32'h70430003};

      rst = 1'b1; flush = 1'b0; in_valid = '0; in_instr = '0; in_pc = '0; issue_count = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      chk("reset out_valid", 32'(out_valid), 32'h0);
      chk("reset in_ready", 32'(in_ready), 32'h1);

      // Two ALU ops issue together, then drain.
      step(2'b11, ADDU, ADDU, 32'h100, 32'h104, 2'd0, 1'b0, 1'b0, "t1 push");
      chk("t1 valid", 32'(out_valid), 32'h3);
      chk("t1 btype", 32'(out_branch_type), 32'h0);
      step(2'b00, 0, 0, 0, 0, 2'd2, 1'b0, 1'b0, "t1 pop");
      chk("t1 drained", 32'(out_valid), 32'h0);

      // Branch waits for its delay slot.
      step(2'b01, BEQ, 0, 32'h200, 0, 2'd0, 1'b0, 1'b0, "t2 beq");
      chk("t2 beq alone", 32'(out_valid), 32'h0);
      step(2'b01, ADDU, 0, 32'h204, 0, 2'd0, 1'b0, 1'b0, "t2 slot");
      chk("t2 pair valid", 32'(out_valid), 32'h3);
      chk("t2 lane0 type", 32'(out_branch_type[2:0]), 32'(B_EQNE));
      step(2'b00, 0, 0, 0, 0, 2'd2, 1'b0, 1'b0, "t2 pop");

      // Two HI/LO users never share a group.
      step(2'b11, MULT, MFLO, 32'h300, 32'h304, 2'd0, 1'b0, 1'b0, "t3 push");
      chk("t3 valid", 32'(out_valid), 32'h1);
      chk("t3 hilo0", 32'(out_is_hilo[0]), 32'h1);
      step(2'b00, 0, 0, 0, 0, 2'd1, 1'b0, 1'b0, "t3 pop1");
      chk("t3 mflo instr", out_instr[31:0], MFLO);
      chk("t3 mflo hilo", 32'(out_is_hilo[0]), 32'h1);
      chk("t3 mflo valid", 32'(out_valid), 32'h1);
      step(2'b00, 0, 0, 0, 0, 2'd1, 1'b0, 1'b0, "t3 pop2");

      // Linking branches.
      step(2'b11, BGEZAL, JALR, 32'h400, 32'h404, 2'd0, 1'b0, 1'b0, "t4 push");
      chk("t4 valid", 32'(out_valid), 32'h1);
      chk("t4 link", 32'(out_is_link), 32'h3);
      chk("t4 type0", 32'(out_branch_type[2:0]), 32'(B_LTGE));
      chk("t4 type1", 32'(out_branch_type[5:3]), 32'(B_JREG));
      step(2'b00, 0, 0, 0, 0, 2'd1, 1'b0, 1'b0, "t4 pop1");
      chk("t4 jalr alone", 32'(out_valid), 32'h0);
      step(2'b01, ADDU, 0, 32'h408, 0, 2'd0, 1'b0, 1'b0, "t4 slot");
      step(2'b00, 0, 0, 0, 0, 2'd2, 1'b0, 1'b0, "t4 pop2");

      // Fill to 7, then stream across the pointer wrap.
      pc = 32'h1000;
      for (int i = 0; i < 3; i++) begin
         step(2'b11, ADDU, ADDU, pc, pc + 4, 2'd0, 1'b0, 1'b0, "t5 fill");
         pc += 8;
      end
      step(2'b01, ADDU, 0, pc, 0, 2'd0, 1'b0, 1'b0, "t5 fill7");
      pc += 4;
      chk("t5 full ready", 32'(in_ready), 32'h0);
      for (int i = 0; i < 20; i++) begin
         step(2'b11, ADDU, ADDU, pc, pc + 4, 2'd2, 1'b0, 1'b0, "t5 stream");
         pc += 8;
      end
      repeat (5) step(2'b00, 0, 0, 0, 0, 2'd2, 1'b0, 1'b0, "t5 drain");

      // Flush beats same-cycle push and pop.
      step(2'b11, ADDU, ADDU, 32'h2000, 32'h2004, 2'd0, 1'b0, 1'b0, "t6 pre");
      step(2'b11, ADDU, ADDU, 32'h2008, 32'h200C, 2'd2, 1'b1, 1'b0, "t6 flush");
      chk("t6 valid", 32'(out_valid), 32'h0);
      chk("t6 ready", 32'(in_ready), 32'h1);
      for (int i = 0; i < 4; i++) begin
         step(2'b11, ADDU, ADDU, pc, pc + 4, 2'd0, 1'b0, 1'b0, "t6 refill");
         pc += 8;
      end
      chk("t6 refill full", 32'(in_ready), 32'h0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         r  = int'($urandom_range(0, 16));
         w0 = (r == 16) ? $urandom : table_w[r];
         r  = int'($urandom_range(0, 16));
         w1 = (r == 16) ? $urandom : table_w[r];
         r  = int'($urandom_range(0, 2));
         v  = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
         ic = 2'($urandom_range(0, 3));
         step(v, w0, w1, pc, pc + 4, ic, ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 63) == 0), "rand");
         pc += 8;
      end
      check_outputs("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
